alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage_pkg.sv | 35 +++
 rtl/alu_issue_stage_decode.sv | 91 +++++++++
 rtl/alu_issue_stage.sv | 87 ++++++++
 tb/tb_alu_issue_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU op-code and RISC-V opcode constants for the ALU issue stage and the ALU.
package alu_issue_stage_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_SRL     = 4'b0100;
  localparam logic [3:0] ALU_SLL     = 4'b0101;
  localparam logic [3:0] ALU_ILLEGAL = 4'b0000;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic {EMPTY, FULL} issueStateT;

  // Reference ALU operation; shifts use the low five bits of the second operand.
  function automatic logic [31:0] aluExec(input logic [3:0] ctrl, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] res;
    res = '0;
    case (ctrl)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_XOR: res = a ^ b;
      ALU_SRL: res = a >> b[4:0];
      ALU_SLL: res = a << b[4:0];
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational RISC-V decode into ALU op code, operands and request attributes.
module alu_decode
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  output logic [3:0]      ctrl,
  output logic [XLEN-1:0] op1,
  output logic [XLEN-1:0] op2,
  output logic            isBranch,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] immI;
  logic [XLEN-1:0] immS;
  logic [XLEN-1:0] shamt;
  logic            unusedRsIdx;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign funct7      = instr[31:25];
  assign immI        = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign immS        = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign shamt       = {{(XLEN-5){1'b0}}, instr[24:20]};
  assign unusedRsIdx = ^instr[19:15];

  // Start from the illegal encoding; each recognised form overrides all fields.
  always_comb begin
    ctrl     = ALU_ILLEGAL;
    op1      = '0;
    op2      = '0;
    isBranch = 1'b0;
    illegal  = 1'b1;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000 && funct3 inside {3'b000, 3'b100, 3'b101, 3'b001}) begin
          illegal = 1'b0;
          op1     = rs1Data;
          op2     = rs2Data;
          case (funct3)
            3'b000:  ctrl = ALU_ADD;
            3'b100:  ctrl = ALU_XOR;
            3'b101:  ctrl = ALU_SRL;
            default: ctrl = ALU_SLL;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          illegal = 1'b0;
          ctrl    = ALU_SUB;
          op1     = rs1Data;
          op2     = rs2Data;
        end
      end
      OP_I: begin
        if (funct3 == 3'b000 || funct3 == 3'b100) begin
          illegal = 1'b0;
          ctrl    = (funct3 == 3'b000) ? ALU_ADD : ALU_XOR;
          op1     = rs1Data;
          op2     = immI;
        end else if ((funct3 == 3'b001 || funct3 == 3'b101) && funct7 == 7'b0000000) begin
          illegal = 1'b0;
          ctrl    = (funct3 == 3'b001) ? ALU_SLL : ALU_SRL;
          op1     = rs1Data;
          op2     = shamt;
        end
      end
      OP_LOAD, OP_STORE: begin
        illegal = 1'b0;
        ctrl    = ALU_ADD;
        op1     = rs1Data;
        op2     = (opcode == OP_LOAD) ? immI : immS;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          illegal  = 1'b0;
          ctrl     = ALU_SUB;
          op1      = rs1Data;
          op2      = rs2Data;
          isBranch = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// One-entry registered issue stage between decode and the ALU, valid/ready handshake.
// Optional feature: define ALU_ISSUE_ILLEGAL_CNT_EN to add the illegalCount output.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inValid,
  output logic            inReady,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  input  logic            flush,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] aluInput1,
  output logic [XLEN-1:0] aluInput2,
  output logic [3:0]      aluControlAlu,
  output logic            isBranch,
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  output logic [15:0]     illegalCount,
`endif
  output logic            illegal
);

  issueStateT      state, stateNext;
  logic            accept;
  logic [3:0]      decCtrl;
  logic [XLEN-1:0] decOp1, decOp2;
  logic            decBranch, decIllegal;

  alu_decode #(.XLEN(XLEN)) uDecode (
    .instr    (instr),
    .rs1Data  (rs1Data),
    .rs2Data  (rs2Data),
    .ctrl     (decCtrl),
    .op1      (decOp1),
    .op2      (decOp2),
    .isBranch (decBranch),
    .illegal  (decIllegal)
  );

  assign outValid = (state == FULL);
  assign inReady  = !outValid || outReady;
  assign accept   = inValid && inReady && !flush;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= stateNext;
  end

  // Flush beats accept; a drain without a new accept empties the stage.
  always_comb begin
    stateNext = state;
    if (flush)                      stateNext = EMPTY;
    else if (accept)                stateNext = FULL;
    else if (state == FULL && outReady) stateNext = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      aluInput1     <= '0;
      aluInput2     <= '0;
      aluControlAlu <= ALU_ILLEGAL;
      isBranch      <= 1'b0;
      illegal       <= 1'b0;
    end else if (accept) begin
      aluInput1     <= decOp1;
      aluInput2     <= decOp2;
      aluControlAlu <= decCtrl;
      isBranch      <= decBranch;
      illegal       <= decIllegal;
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      illegalCount <= '0;
    else if (accept && decIllegal && illegalCount != 16'hFFFF)
      illegalCount <= illegalCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard testbench for alu_issue_stage: directed cases plus a random handshake run.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        br;
    logic        ill;
  } expT;

  logic        clk = 1'b0;
  logic        reset, inValid, inReady, flush, outValid, outReady, isBranch, illegal;
  logic [31:0] instr, rs1Data, rs2Data, aluInput1, aluInput2;
  logic [3:0]  aluControlAlu;
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [15:0] illegalCount;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  expT         sbq[$];
  logic        modelFull = 1'b0;
  int unsigned cntModel  = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .inValid       (inValid),
    .inReady       (inReady),
    .instr         (instr),
    .rs1Data       (rs1Data),
    .rs2Data       (rs2Data),
    .flush         (flush),
    .outValid      (outValid),
    .outReady      (outReady),
    .aluInput1     (aluInput1),
    .aluInput2     (aluInput2),
    .aluControlAlu (aluControlAlu),
    .isBranch      (isBranch),
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    .illegalCount  (illegalCount),
`endif
    .illegal       (illegal)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic expT decodeModel(input logic [31:0] i, input logic [31:0] r1,
                                      input logic [31:0] r2);
    expT e;
    logic [31:0] immI, immS;
    immI = {{20{i[31]}}, i[31:20]};
    immS = {{20{i[31]}}, i[31:25], i[11:7]};
    e = '{ctrl: 4'b0000, a: 32'd0, b: 32'd0, br: 1'b0, ill: 1'b1};
    if (i[6:0] == 7'h33) begin
      if (i[31:25] == 7'h00 && i[14:12] == 3'd0)      e = '{4'b0010, r1, r2, 1'b0, 1'b0};
      else if (i[31:25] == 7'h20 && i[14:12] == 3'd0) e = '{4'b0110, r1, r2, 1'b0, 1'b0};
      else if (i[31:25] == 7'h00 && i[14:12] == 3'd4) e = '{4'b0011, r1, r2, 1'b0, 1'b0};
      else if (i[31:25] == 7'h00 && i[14:12] == 3'd5) e = '{4'b0100, r1, r2, 1'b0, 1'b0};
      else if (i[31:25] == 7'h00 && i[14:12] == 3'd1) e = '{4'b0101, r1, r2, 1'b0, 1'b0};
    end else if (i[6:0] == 7'h13) begin
      if (i[14:12] == 3'd0)      e = '{4'b0010, r1, immI, 1'b0, 1'b0};
      else if (i[14:12] == 3'd4) e = '{4'b0011, r1, immI, 1'b0, 1'b0};
      else if (i[14:12] == 3'd1 && i[31:25] == 7'h00) e = '{4'b0101, r1, {27'd0, i[24:20]}, 1'b0, 1'b0};
      else if (i[14:12] == 3'd5 && i[31:25] == 7'h00) e = '{4'b0100, r1, {27'd0, i[24:20]}, 1'b0, 1'b0};
    end else if (i[6:0] == 7'h03) begin
      e = '{4'b0010, r1, immI, 1'b0, 1'b0};
    end else if (i[6:0] == 7'h23) begin
      e = '{4'b0010, r1, immS, 1'b0, 1'b0};
    end else if (i[6:0] == 7'h63 && (i[14:12] == 3'd0 || i[14:12] == 3'd1)) begin
      e = '{4'b0110, r1, r2, 1'b1, 1'b0};
    end
    return e;
  endfunction

  // One cycle: drive at negedge, check outputs against the model, advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                      input logic [31:0] r2, input logic rdy, input logic fl);
    logic acc;
    expT  e;
    @(negedge clk);
    inValid = v; instr = ins; rs1Data = r1; rs2Data = r2; outReady = rdy; flush = fl;
    #1;
    checkVal("outValid", {31'd0, outValid}, {31'd0, modelFull});
    checkVal("inReady", {31'd0, inReady}, {31'd0, (!modelFull || rdy)});
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    checkVal("illegalCount", {16'd0, illegalCount}, cntModel);
`endif
    if (modelFull && sbq.size() > 0) begin
      e = sbq[0];
      checkVal("ctrl", {28'd0, aluControlAlu}, {28'd0, e.ctrl});
      checkVal("aluInput1", aluInput1, e.a);
      checkVal("aluInput2", aluInput2, e.b);
      checkVal("isBranch", {31'd0, isBranch}, {31'd0, e.br});
      checkVal("illegal", {31'd0, illegal}, {31'd0, e.ill});
    end
    acc = v && (!modelFull || rdy) && !fl;
    if (modelFull && (fl || rdy) && sbq.size() > 0) void'(sbq.pop_front());
    if (acc) begin
      e = decodeModel(ins, r1, r2);
      sbq.push_back(e);
      if (e.ill && cntModel < 32'hFFFF) cntModel++;
    end
    modelFull = fl ? 1'b0 : (acc ? 1'b1 : (rdy ? 1'b0 : modelFull));
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic doReset(input logic holdValid);
    @(negedge clk);
    reset = 1'b1; inValid = holdValid; outReady = 1'b0; flush = 1'b0; instr = 32'h00000033;
    @(posedge clk);
    #1;
    checkVal("rstOutValid", {31'd0, outValid}, 32'd0);
    checkVal("rstCtrl", {28'd0, aluControlAlu}, 32'd0);
    checkVal("rstIn1", aluInput1, 32'd0);
    checkVal("rstIn2", aluInput2, 32'd0);
    checkVal("rstBranch", {31'd0, isBranch}, 32'd0);
    checkVal("rstIllegal", {31'd0, illegal}, 32'd0);
    checkVal("rstInReady", {31'd0, inReady}, 32'd1);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    checkVal("rstCount", {16'd0, illegalCount}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0; inValid = 1'b0;
    sbq.delete();
    modelFull = 1'b0;
    cntModel  = 0;
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] i;
    logic [6:0]  ops [5];
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63};
    i = $urandom;
    case ($urandom_range(0, 7))
      0, 1, 2, 3, 4: i[6:0] = ops[$urandom_range(0, 4)];
      5:       begin i[6:0] = 7'h33; i[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20; end
      6:       begin i[6:0] = 7'h13; i[31:25] = 7'h00; end
      default: ;
    endcase
    return i;
  endfunction

  initial begin
    reset = 1'b1; inValid = 1'b0; outReady = 1'b0; flush = 1'b0;
    instr = '0; rs1Data = '0; rs2Data = '0;
    repeat (2) @(posedge clk);
    doReset(1'b0);

    // sub x3,x1,x2 then check the chained ALU result
    step(1'b1, 32'h402081B3, 32'd5, 32'd3, 1'b1, 1'b0);
    idle(1'b1);
    checkVal("subResult", alu_issue_stage_pkg::aluExec(aluControlAlu, aluInput1, aluInput2), 32'd2);

    // slli shamt 31, addi imm 0xFFF
    step(1'b1, 32'h01F09093, 32'd1, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'hFFF00093, 32'd0, 32'd0, 1'b1, 1'b0);
    idle(1'b1);

    // three-cycle stall with inValid held high, then release: no bubble
    step(1'b1, 32'h002081B3, 32'd7, 32'd9, 1'b1, 1'b0);
    repeat (3) step(1'b1, 32'h0020C1B3, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 1'b0);
    step(1'b1, 32'h0020C1B3, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b1, 1'b0);
    step(1'b1, 32'h00208463, 32'd4, 32'd4, 1'b1, 1'b0);
    idle(1'b1);

    // flush while full and with an incoming instruction
    step(1'b1, 32'h00A12023, 32'h100, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'h00A12083, 32'h200, 32'd0, 1'b0, 1'b1);
    idle(1'b1);

    // all-zero instruction is illegal
    step(1'b1, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // reset while full and stalled
    step(1'b1, 32'h0020D1B3, 32'h80000000, 32'd31, 1'b0, 1'b0);
    idle(1'b0);
    doReset(1'b1);
    idle(1'b1);

    for (int unsigned n = 0; n < 400; n++) begin
      step(($urandom_range(0, 3) != 0), randInstr(), $urandom, $urandom,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
    end
    repeat (2) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
